rs_dec_gf8_seq: RTL and testbench



---
 rtl/rs_gf8_pkg.sv | 36 +++
 rtl/gf_inv_3.sv | 25 ++
 rtl/rs_dec_gf8_seq.sv | 204 ++++++++++++++++++++
 tb/tb_rs_dec_gf8_seq.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_gf8_pkg.sv
// Shared definitions for the GF(2^3) Reed-Solomon (7,5) decoder.
// Holds the symbol type, code constants, field constants, the state
// encoding and the combinational GF(8) multiplier
// (primitive polynomial x^3+x+1).
package rs_gf8_pkg;

  typedef logic [2:0] sym_t;

  localparam int N = 7;
  localparam int K = 5;

  localparam sym_t ALPHA     = 3'd2;  // a
  localparam sym_t ALPHA2    = 3'd4;  // a^2
  localparam sym_t ALPHA_INV = 3'd5;  // a^-1 = a^6
  localparam sym_t ALPHA_N1  = 3'd5;  // a^(N-1), locator of the first symbol

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    CALC1   = 2'd1,
    CALC2   = 2'd2,
    EMIT    = 2'd3
  } state_t;

  // Carry-less multiply, then fold x^4 and x^3 back using x^3 = x + 1.
  function automatic sym_t gf_mul(input sym_t a, input sym_t b);
    logic [4:0] p;
    p = '0;
    for (int i = 0; i < 3; i++) begin
      if (b[i]) p = p ^ ({2'b00, a} << i);
    end
    if (p[4]) p = p ^ 5'b10110;
    if (p[3]) p = p ^ 5'b01011;
    return p[2:0];
  endfunction

endpackage

// File: rtl/gf_inv_3.sv
// Combinational multiplicative inverse in GF(2^3), x^3+x+1.
// Ports: a - input symbol; y - inverse of a (0 maps to 0).
module gf_inv_3
  import rs_gf8_pkg::*;
(
  input  sym_t a,
  output sym_t y
);

  always_comb begin
    y = 3'd0;
    case (a)
      3'd0: y = 3'd0;
      3'd1: y = 3'd1;
      3'd2: y = 3'd5;
      3'd3: y = 3'd6;
      3'd4: y = 3'd7;
      3'd5: y = 3'd2;
      3'd6: y = 3'd3;
      3'd7: y = 3'd4;
      default: y = 3'd0;
    endcase
  end

endmodule

// File: rtl/rs_dec_gf8_seq.sv
// Sequential single-error-correcting RS(7,5) decoder over GF(2^3).
// Collects a 7-symbol codeword (degree 6 first) while accumulating the
// syndromes S1=r(a), S2=r(a^2); spends two cycles on the error locator
// X=S2/S1 and value E=S1/X through one shared inverter; then streams the
// corrected codeword out in input order.
// Ports:
//   clk, rst              - clock, asynchronous active-high reset
//   din/din_valid/din_ready     - input symbol stream
//   dout/dout_valid/dout_ready  - corrected output stream
//   dout_last             - marks the 7th output symbol
//   err_corr/err_uncorr   - codeword status, valid with dout_last only
module rs_dec_gf8_seq
  import rs_gf8_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic [2:0] dout,
  output logic       dout_valid,
  input  logic       dout_ready,
  output logic       dout_last,
  output logic       err_corr,
  output logic       err_uncorr
);

  localparam logic [2:0] LAST_IDX = 3'(N - 1);

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  sym_t       s1_q, s1_d, s2_q, s2_d;
  sym_t       x_q, x_d, e_q, e_d;
  sym_t       loc_q, loc_d;
  logic       corr_q, corr_d, uncorr_q, uncorr_d;
  logic       din_ready_q, din_ready_d;
  sym_t       dout_q, dout_d;
  logic       dout_valid_q, dout_valid_d;
  logic       dout_last_q, dout_last_d;
  logic       err_corr_q, err_corr_d;
  logic       err_uncorr_q, err_uncorr_d;
  sym_t       sym_buf_q [N];
  sym_t       sym_buf_d [N];

  sym_t       inv_in, inv_out;
  logic       in_fire, out_fire;
  logic       s1_zero, s2_zero;
  sym_t       e_new;
  logic [2:0] cnt_n;
  sym_t       loc_n;

  // Single inverter: S1 during CALC1 (for X), X during CALC2 (for E).
  assign inv_in = (state_q == CALC2) ? x_q : s1_q;

  gf_inv_3 u_inv (
    .a (inv_in),
    .y (inv_out)
  );

  assign in_fire  = din_valid & din_ready_q;
  assign out_fire = dout_valid_q & dout_ready;

  assign din_ready  = din_ready_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign dout_last  = dout_last_q;
  assign err_corr   = err_corr_q;
  assign err_uncorr = err_uncorr_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    s1_d         = s1_q;
    s2_d         = s2_q;
    x_d          = x_q;
    e_d          = e_q;
    loc_d        = loc_q;
    corr_d       = corr_q;
    uncorr_d     = uncorr_q;
    din_ready_d  = din_ready_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    dout_last_d  = dout_last_q;
    err_corr_d   = err_corr_q;
    err_uncorr_d = err_uncorr_q;
    sym_buf_d    = sym_buf_q;
    s1_zero      = (s1_q == 3'd0);
    s2_zero      = (s2_q == 3'd0);
    e_new        = 3'd0;
    cnt_n        = cnt_q + 3'd1;
    loc_n        = gf_mul(loc_q, ALPHA_INV);

    case (state_q)
      COLLECT: begin
        din_ready_d = 1'b1;
        if (in_fire) begin
          sym_buf_d[cnt_q] = din;
          // Horner evaluation of r(a) and r(a^2), highest degree first.
          s1_d = gf_mul(s1_q, ALPHA) ^ din;
          s2_d = gf_mul(s2_q, ALPHA2) ^ din;
          if (cnt_q == LAST_IDX) begin
            cnt_d       = 3'd0;
            din_ready_d = 1'b0;
            state_d     = CALC1;
          end else begin
            cnt_d = cnt_n;
          end
        end
      end

      CALC1: begin
        x_d     = gf_mul(s2_q, inv_out);
        state_d = CALC2;
      end

      CALC2: begin
        corr_d   = !s1_zero && !s2_zero;
        uncorr_d = s1_zero ^ s2_zero;
        // Only a locatable single error carries a nonzero value.
        e_new    = (!s1_zero && !s2_zero) ? gf_mul(s1_q, inv_out) : 3'd0;
        e_d      = e_new;
        // First output (degree 6) is prepared here so it is registered
        // and valid on the first EMIT cycle.
        dout_d       = sym_buf_q[0] ^ ((loc_q == x_q) ? e_new : 3'd0);
        dout_valid_d = 1'b1;
        dout_last_d  = 1'b0;
        err_corr_d   = 1'b0;
        err_uncorr_d = 1'b0;
        state_d      = EMIT;
      end

      EMIT: begin
        if (out_fire) begin
          if (cnt_q == LAST_IDX) begin
            state_d      = COLLECT;
            cnt_d        = 3'd0;
            loc_d        = ALPHA_N1;
            s1_d         = 3'd0;
            s2_d         = 3'd0;
            x_d          = 3'd0;
            e_d          = 3'd0;
            din_ready_d  = 1'b1;
            dout_d       = 3'd0;
            dout_valid_d = 1'b0;
            dout_last_d  = 1'b0;
            err_corr_d   = 1'b0;
            err_uncorr_d = 1'b0;
          end else begin
            cnt_d        = cnt_n;
            loc_d        = loc_n;
            dout_d       = sym_buf_q[cnt_n] ^ ((loc_n == x_q) ? e_q : 3'd0);
            dout_last_d  = (cnt_n == LAST_IDX);
            err_corr_d   = (cnt_n == LAST_IDX) && corr_q;
            err_uncorr_d = (cnt_n == LAST_IDX) && uncorr_q;
          end
        end
      end

      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= COLLECT;
      cnt_q        <= 3'd0;
      s1_q         <= 3'd0;
      s2_q         <= 3'd0;
      x_q          <= 3'd0;
      e_q          <= 3'd0;
      loc_q        <= ALPHA_N1;
      corr_q       <= 1'b0;
      uncorr_q     <= 1'b0;
      din_ready_q  <= 1'b0;
      dout_q       <= 3'd0;
      dout_valid_q <= 1'b0;
      dout_last_q  <= 1'b0;
      err_corr_q   <= 1'b0;
      err_uncorr_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      x_q          <= x_d;
      e_q          <= e_d;
      loc_q        <= loc_d;
      corr_q       <= corr_d;
      uncorr_q     <= uncorr_d;
      din_ready_q  <= din_ready_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      dout_last_q  <= dout_last_d;
      err_corr_q   <= err_corr_d;
      err_uncorr_q <= err_uncorr_d;
    end
  end

  // Symbol storage carries data only; every entry is rewritten before use.
  always_ff @(posedge clk) begin
    sym_buf_q <= sym_buf_d;
  end

endmodule

// File: tb/tb_rs_dec_gf8_seq.sv
module tb_rs_dec_gf8_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] din = 3'd0;
  logic       din_valid = 1'b0;
  logic       din_ready;
  logic [2:0] dout;
  logic       dout_valid;
  logic       dout_ready = 1'b1;
  logic       dout_last;
  logic       err_corr;
  logic       err_uncorr;

  always #5 clk = ~clk;

  rs_dec_gf8_seq dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_last  (dout_last),
    .err_corr   (err_corr),
    .err_uncorr (err_uncorr)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Antilog table a^0..a^6 for a=2 over x^3+x+1.
  logic [2:0] EXP [7] = '{3'd1, 3'd2, 3'd4, 3'd3, 3'd6, 3'd7, 3'd5};

  logic [2:0] tx [7];     // tx[i] has degree 6-i
  logic [2:0] orig [7];
  logic [2:0] rx [7];
  logic       rx_corr, rx_unc;
  logic [2:0] mdl_out [7];
  logic       mdl_corr, mdl_unc;

  function automatic int glog(input logic [2:0] v);
    for (int i = 0; i < 7; i++) if (EXP[i] == v) return i;
    return 0;
  endfunction

  function automatic logic [2:0] gmul(input logic [2:0] a, input logic [2:0] b);
    if (a == 3'd0 || b == 3'd0) return 3'd0;
    return EXP[(glog(a) + glog(b)) % 7];
  endfunction

  function automatic logic [2:0] gdiv(input logic [2:0] a, input logic [2:0] b);
    if (a == 3'd0 || b == 3'd0) return 3'd0;
    return EXP[(glog(a) - glog(b) + 7) % 7];
  endfunction

  function automatic logic [2:0] apow(input int k);
    return EXP[k % 7];
  endfunction

  // Reference decoder: syndromes by direct evaluation, single-error solve.
  task automatic model_decode();
    logic [2:0] s1, s2, x, e;
    s1 = 3'd0; s2 = 3'd0;
    for (int i = 0; i < 7; i++) begin
      s1 ^= gmul(tx[i], apow(6 - i));
      s2 ^= gmul(tx[i], apow(2 * (6 - i)));
    end
    for (int i = 0; i < 7; i++) mdl_out[i] = tx[i];
    mdl_corr = 1'b0; mdl_unc = 1'b0;
    if (s1 != 3'd0 && s2 != 3'd0) begin
      x = gdiv(s2, s1);
      e = gdiv(s1, x);
      mdl_out[6 - glog(x)] ^= e;
      mdl_corr = 1'b1;
    end else if (s1 != 3'd0 || s2 != 3'd0) begin
      mdl_unc = 1'b1;
    end
  endtask

  // Random valid codeword: five random high symbols, two parity symbols
  // chosen so that r(a) = r(a^2) = 0.
  task automatic make_codeword();
    logic [2:0] p1, p2, c1;
    p1 = 3'd0; p2 = 3'd0;
    for (int i = 0; i < 5; i++) begin
      tx[i] = 3'($urandom_range(0, 7));
      p1 ^= gmul(tx[i], apow(6 - i));
      p2 ^= gmul(tx[i], apow(2 * (6 - i)));
    end
    c1 = gdiv(p1 ^ p2, 3'd6);  // a + a^2 = 6
    tx[5] = c1;
    tx[6] = p1 ^ gmul(c1, 3'd2);
    for (int i = 0; i < 7; i++) orig[i] = tx[i];
  endtask

  // Starts and ends at a negedge; returns cycles from the last input
  // transfer cycle to the first cycle with dout_valid.
  task automatic send_cw(output int cycles);
    int n;
    for (int i = 0; i < 7; i++) begin
      din = tx[i];
      din_valid = 1'b1;
      n = 0;
      while (din_ready !== 1'b1 && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (n >= 50) begin
        n_checks++;
        n_fail++;
        $display("FAIL din_ready_timeout sym=%0d got din_ready=%b want 1", i, din_ready);
      end
      @(negedge clk);
    end
    din_valid = 1'b0;
    din = 3'd0;
    n = 0;
    while (dout_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    cycles = n + 1;
  endtask

  // mode 0: always ready; mode 1: ready pattern 1,0,0,1 repeating.
  task automatic recv_cw(input int mode);
    int got, cyc;
    logic stalled;
    logic [2:0] pd;
    logic pl, pc, pu;
    got = 0; cyc = 0; stalled = 1'b0;
    pd = 3'd0; pl = 1'b0; pc = 1'b0; pu = 1'b0;
    while (got < 7 && cyc < 200) begin
      dout_ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      if (stalled) begin
        n_checks++;
        if ({dout_valid, dout, dout_last, err_corr, err_uncorr} !== {1'b1, pd, pl, pc, pu}) begin
          n_fail++;
          $display("FAIL stall_hold got v=%b d=%0d l=%b c=%b u=%b want v=1 d=%0d l=%b c=%b u=%b",
                   dout_valid, dout, dout_last, err_corr, err_uncorr, pd, pl, pc, pu);
        end
      end
      if (dout_valid === 1'b1) begin
        n_checks++;
        if (dout_last !== (got == 6)) begin
          n_fail++;
          $display("FAIL dout_last idx=%0d got %b want %b", got, dout_last, (got == 6));
        end
        n_checks++;
        if (dout_last !== 1'b1 && {err_corr, err_uncorr} !== 2'b00) begin
          n_fail++;
          $display("FAIL flags_without_last idx=%0d got %b%b want 00", got, err_corr, err_uncorr);
        end
        if (dout_ready) begin
          rx[got] = dout;
          if (got == 6) begin
            rx_corr = err_corr;
            rx_unc  = err_uncorr;
          end
          got++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          pd = dout; pl = dout_last; pc = err_corr; pu = err_uncorr;
        end
      end else begin
        stalled = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    dout_ready = 1'b1;
    n_checks++;
    if (got != 7) begin
      n_fail++;
      $display("FAIL recv_timeout got %0d transfers want 7", got);
    end
    n_checks++;
    if ({dout_valid, din_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL after_last got dout_valid=%b din_ready=%b want 0 1", dout_valid, din_ready);
    end
  endtask

  task automatic check_directed(input string name, input logic [20:0] want,
                                input logic want_c, input logic want_u);
    logic [20:0] got;
    for (int i = 0; i < 7; i++) got[20 - 3*i -: 3] = rx[i];
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s_data got %h want %h", name, got, want);
    end
    n_checks++;
    if ({rx_corr, rx_unc} !== {want_c, want_u}) begin
      n_fail++;
      $display("FAIL %s_flags got c=%b u=%b want c=%b u=%b", name, rx_corr, rx_unc, want_c, want_u);
    end
  endtask

  task automatic check_latency(input string name, input int cycles);
    n_checks++;
    if (cycles != 3) begin
      n_fail++;
      $display("FAIL %s_latency got %0d cycles want 3", name, cycles);
    end
  endtask

  task automatic test_reset();
    int lat;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({din_ready, dout_valid, dout, dout_last, err_corr, err_uncorr} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs got rdy=%b v=%b d=%0d l=%b c=%b u=%b want all 0",
               din_ready, dout_valid, dout, dout_last, err_corr, err_uncorr);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (din_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready got %b want 1", din_ready);
    end
    lat = 0;
  endtask

  task automatic test_zero_codeword();
    int lat;
    for (int i = 0; i < 7; i++) tx[i] = 3'd0;
    send_cw(lat);
    check_latency("zero", lat);
    recv_cw(0);
    check_directed("zero", 21'h0, 1'b0, 1'b0);
  endtask

  task automatic test_single_error();
    int lat;
    for (int i = 0; i < 7; i++) tx[i] = 3'd0;
    tx[3] = 3'd5;
    send_cw(lat);
    check_latency("single", lat);
    recv_cw(0);
    check_directed("single", 21'h0, 1'b1, 1'b0);
  endtask

  task automatic test_uncorrectable();
    int lat;
    for (int i = 0; i < 7; i++) tx[i] = 3'd0;
    tx[5] = 3'd7;
    tx[6] = 3'd1;
    send_cw(lat);
    check_latency("uncorr", lat);
    recv_cw(0);
    check_directed("uncorr", {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd7, 3'd1}, 1'b0, 1'b1);
  endtask

  task automatic test_stall();
    int lat;
    for (int i = 0; i < 7; i++) tx[i] = 3'd0;
    tx[3] = 3'd5;
    send_cw(lat);
    recv_cw(1);
    check_directed("stall", 21'h0, 1'b1, 1'b0);
  endtask

  task automatic test_rst_in_emit();
    int lat, got, n;
    for (int i = 0; i < 7; i++) tx[i] = 3'd0;
    tx[3] = 3'd5;
    send_cw(lat);
    dout_ready = 1'b1;
    got = 0; n = 0;
    while (got < 2 && n < 20) begin
      if (dout_valid === 1'b1) got++;
      @(negedge clk);
      n++;
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({dout_valid, dout_last, din_ready} !== 3'b000) begin
      n_fail++;
      $display("FAIL rst_emit_outputs got v=%b l=%b rdy=%b want 0 0 0", dout_valid, dout_last, din_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_zero_codeword();
  endtask

  task automatic test_back_to_back();
    int lat, pos, errs;
    logic [2:0] val;
    logic [20:0] got, want;
    errs = 0;
    for (int it = 0; it < 1000; it++) begin
      make_codeword();
      pos = $urandom_range(0, 6);
      val = 3'($urandom_range(1, 7));
      tx[6 - pos] ^= val;
      model_decode();
      send_cw(lat);
      check_latency("b2b", lat);
      recv_cw(it % 2);
      for (int i = 0; i < 7; i++) begin
        got[20 - 3*i -: 3]  = rx[i];
        want[20 - 3*i -: 3] = orig[i];
      end
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL b2b_data it=%0d pos=%0d val=%0d got %h want %h", it, pos, val, got, want);
      end
      n_checks++;
      if ({rx_corr, rx_unc} !== {mdl_corr, mdl_unc} || rx_corr !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_flags it=%0d got c=%b u=%b want c=1 u=0", it, rx_corr, rx_unc);
      end
    end
    errs = 0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_zero_codeword();
    test_single_error();
    test_uncorrectable();
    test_stall();
    test_rst_in_emit();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
